// File: rtl/bias_load_ctrl.sv
// bias_load_ctrl: serial-to-parallel bias vector loader.
// Collects NW = NUM_FEATURES+1 words from a valid/ready stream into a shadow
// buffer. A correct-length burst is committed to the bias memory with a
// single-cycle active-low write pulse. Short or long bursts raise a sticky
// length error and leave the memory untouched.
module bias_load_ctrl #(
  parameter int NUM_FEATURES = 3,
  parameter int DATA_WIDTH   = 8,
  localparam int NW          = NUM_FEATURES + 1,
  localparam int IW          = $clog2(NW + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [DATA_WIDTH-1:0]      in_data,
  input  logic                              in_last,
  output logic                              bias_WrEn,
  output logic [NW-1:0][DATA_WIDTH-1:0]     bias_weights_input,
  output logic                              busy,
  output logic                              done,
  output logic                              err_len
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    STAGE = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  state_t                         state;
  logic [IW-1:0]                  idx;
  logic [NW-1:0][DATA_WIDTH-1:0]  shadow;
  logic                           xfer;

  // Stream is only open while collecting or discarding words.
  assign in_ready = (state == LOAD) || (state == DRAIN);
  assign busy     = (state != IDLE);
  assign xfer     = in_valid && in_ready;

  // Sequencer: collect, check length, stage, pulse write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      idx                <= '0;
      shadow             <= '0;
      bias_weights_input <= '0;
      bias_WrEn          <= 1'b1;
      done               <= 1'b0;
      err_len            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            idx     <= '0;
            err_len <= 1'b0;
          end
        end
        LOAD: begin
          // abort wins over a same-cycle word; that word is dropped
          if (abort) begin
            state <= IDLE;
          end else if (xfer) begin
            for (int i = 0; i < NW; i++)
              if (idx == IW'(i)) shadow[i] <= in_data;
            if (in_last) begin
              if (idx == LAST_IDX) begin
                state <= STAGE;
              end else begin
                err_len <= 1'b1;
                state   <= IDLE;
              end
            end else if (idx == LAST_IDX) begin
              err_len <= 1'b1;
              state   <= DRAIN;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        DRAIN: begin
          // swallow the tail of an over-long burst
          if (abort || (xfer && in_last)) state <= IDLE;
        end
        STAGE: begin
          // vector and write enable change together so the memory
          // sees settled data for the whole WRITE cycle
          bias_weights_input <= shadow;
          bias_WrEn          <= 1'b0;
          state              <= WRITE;
        end
        WRITE: begin
          bias_WrEn <= 1'b1;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_load_ctrl.sv
// Scoreboard bench for bias_load_ctrl: the driver predicts each burst's
// outcome from the length/abort rules and queues expected commits; a
// negedge monitor checks every write pulse and done pulse against the queue.
module tb_bias_load_ctrl;
  localparam int NF = 3;
  localparam int DW = 8;
  localparam int NW = NF + 1;

  logic clk = 0;
  logic rst, start, abort, in_valid, in_last;
  logic signed [DW-1:0] in_data;
  logic in_ready, bias_WrEn, busy, done, err_len;
  logic [NW-1:0][DW-1:0] bwi;

  int checks = 0;
  int failures = 0;
  logic [NW*DW-1:0] exp_q[$];
  logic [NW*DW-1:0] cur_vec;
  bit mon_en = 0;
  bit exp_done = 0;
  bit prev_low = 0;

  bias_load_ctrl #(.NUM_FEATURES(NF), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .bias_WrEn(bias_WrEn),
    .bias_weights_input(bwi), .busy(busy), .done(done), .err_len(err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every low write-enable cycle must match the next queued commit.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("done_pulse", {63'd0, done}, {63'd0, exp_done});
      if (bias_WrEn === 1'b0) begin
        chk("wren_single_cycle", {63'd0, prev_low}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          logic [NW*DW-1:0] e;
          e = exp_q.pop_front();
          chk("commit_vector", {32'd0, bwi}, {32'd0, e});
        end
      end
      exp_done = (bias_WrEn === 1'b0) && !rst;
      prev_low = (bias_WrEn === 1'b0);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  // One load: len words (last on the final one), optional abort on word
  // abort_at, optional gaps, optional abort with start, optional reset in WRITE.
  task automatic do_load(input int len, input int abort_at, input bit gaps,
                         input bit start_abort, input bit rst_wr,
                         input logic [NW*DW-1:0] data);
    bit aborted, commit, exp_err;
    logic [DW-1:0] w;
    aborted = (abort_at >= 0) && (abort_at < len);
    commit  = !aborted && (len == NW);
    exp_err = aborted ? (abort_at >= NW) : (len != NW);
    if (commit) exp_q.push_back(data);

    start = 1; abort = start_abort;
    @(posedge clk); #1;
    start = 0; abort = 0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("err_cleared_on_start", {63'd0, err_len}, 64'd0);

    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          in_valid = 0; in_data = DW'($urandom); in_last = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      w = (i < NW) ? data[i*DW +: DW] : DW'($urandom);
      in_valid = 1; in_data = w; in_last = (i == len - 1);
      abort = (i == abort_at); start = 1'($urandom);
      chk("in_ready_open", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 0; in_last = 0; abort = 0; start = 0; in_data = DW'($urandom);
      if (i == abort_at) break;
      if (len > NW && i >= NW - 1)
        chk("err_len_long", {63'd0, err_len}, 64'd1);
    end

    if (rst_wr) begin
      @(posedge clk); #1;        // now in WRITE
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      cur_vec = '0;
      chk("rst_wr_wren", {63'd0, bias_WrEn}, 64'd1);
      chk("rst_wr_vec", {32'd0, bwi}, 64'd0);
      chk("rst_wr_busy", {63'd0, busy}, 64'd0);
      chk("rst_wr_done", {63'd0, done}, 64'd0);
    end else begin
      wait_idle();
      if (commit) cur_vec = data;
      @(posedge clk); #1;
      chk("err_len", {63'd0, err_len}, {63'd0, exp_err});
      chk("vector_hold", {32'd0, bwi}, {32'd0, cur_vec});
    end
    chk("wren_idle", {63'd0, bias_WrEn}, 64'd1);
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; in_valid = 0; in_last = 0; in_data = '0;
    cur_vec = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec", {32'd0, bwi}, 64'd0);
    chk("rst_wren", {63'd0, bias_WrEn}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err_len}, 64'd0);
    rst = 0;
    mon_en = 1;
    @(posedge clk); #1;

    // nominal: {5,-5,127,-128}
    do_load(4, -1, 0, 0, 0, 32'h807FFB05);
    chk("nominal_vec", {32'd0, bwi}, 64'h807FFB05);
    // gaps with garbage on idle cycles
    do_load(4, -1, 1, 0, 0, 32'h807FFB05);
    // short burst keeps prior vector
    do_load(2, -1, 0, 0, 0, 32'h11223344);
    // long burst then correct load
    do_load(6, -1, 0, 0, 0, 32'h55667788);
    do_load(4, -1, 0, 0, 0, 32'h01020304);
    // abort with the 2nd word
    do_load(4, 1, 0, 0, 0, 32'hAABBCCDD);
    // start together with abort in IDLE still starts
    do_load(4, -1, 0, 1, 0, 32'hF00DBEEF);
    // reset during WRITE
    do_load(4, -1, 0, 0, 1, 32'h13579BDF);

    for (int t = 0; t < 40; t++) begin
      int len, ab;
      len = $urandom_range(1, 7);
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      do_load(len, ab, 1'($urandom), 1'($urandom), 0, $urandom);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
